// File: rtl/lc3_mem_pkg.sv
// ----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared widths and state encoding for the SLC-3 memory access unit.
//   WORD_W      : datapath / bus width
//   CNT_W       : width of the SRAM wait-cycle counter
//   mem_state_t : access sequencer states
// ----------------------------------------------------------------------------
package lc3_mem_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_access_unit_reg_16.sv
// ----------------------------------------------------------------------------
// reg_16
// 16-bit register with synchronous active-high reset and a load enable.
// Used for both MAR and MDR.
//   i_clk   : clock
//   i_reset : synchronous reset, clears the register to 0
//   i_ld    : load enable
//   i_d     : data input
//   o_q     : register contents
// ----------------------------------------------------------------------------
module reg_16
    import lc3_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ld,
    input  logic [WORD_W-1:0] i_d,
    output logic [WORD_W-1:0] o_q
);

    logic [WORD_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// MAR/MDR register pair plus a fixed-latency SRAM access sequencer for the
// SLC-3 datapath. MAR/MDR load from the internal bus; reads return SRAM data
// into MDR.
//   Clk, Reset      : clock, synchronous active-high reset
//   BUS             : internal bus value
//   LD_MAR, LD_MDR  : load MAR / MDR from BUS (ignored while an access waits)
//   MEM_REQ, MEM_WE : start access, access type (1 = write)
//   Data_from_SRAM  : SRAM read data
//   MAR, MDR        : register contents
//   ADDR            : SRAM address (copy of MAR)
//   Data_to_SRAM    : SRAM write data (copy of MDR)
//   mem_rd, mem_wr  : SRAM strobes, high for the WAIT cycles only
//   BUSY            : access in progress
//   MEM_RDY         : one-cycle completion pulse
// ----------------------------------------------------------------------------
module mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WORD_W-1:0] BUS,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MEM_REQ,
    input  logic              MEM_WE,
    input  logic [WORD_W-1:0] Data_from_SRAM,
    output logic [WORD_W-1:0] MAR,
    output logic [WORD_W-1:0] MDR,
    output logic [WORD_W-1:0] ADDR,
    output logic [WORD_W-1:0] Data_to_SRAM,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              BUSY,
    output logic              MEM_RDY
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    mem_state_t        r_state;
    logic              r_type;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_rd;
    logic              r_wr;
    logic              r_rdy;

    logic              w_in_wait;
    logic              w_rd_capture;
    logic              w_ld_mar;
    logic              w_ld_mdr;
    logic [WORD_W-1:0] w_mdr_d;

    // Bus loads are blocked during WAIT so address and write data hold steady.
    assign w_in_wait    = (r_state == WAIT);
    assign w_rd_capture = w_in_wait && (r_cnt == '0) && !r_type;
    assign w_ld_mar     = LD_MAR && !w_in_wait;
    assign w_ld_mdr     = (LD_MDR && !w_in_wait) || w_rd_capture;
    assign w_mdr_d      = w_rd_capture ? Data_from_SRAM : BUS;

    reg_16 u_mar (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_ld    (w_ld_mar),
        .i_d     (BUS),
        .o_q     (MAR)
    );

    reg_16 u_mdr (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_ld    (w_ld_mdr),
        .i_d     (w_mdr_d),
        .o_q     (MDR)
    );

    // Strobes/BUSY/MEM_RDY are registered alongside the state so they are
    // valid for exactly the cycles the state occupies.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_type  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (MEM_REQ) begin
                        r_state <= WAIT;
                        r_type  <= MEM_WE;
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_rd    <= !MEM_WE;
                        r_wr    <= MEM_WE;
                        r_rdy   <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_rdy   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign ADDR         = MAR;
    assign Data_to_SRAM = MDR;
    assign mem_rd       = r_rd;
    assign mem_wr       = r_wr;
    assign BUSY         = r_busy;
    assign MEM_RDY      = r_rdy;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] BUS;
    logic        LD_MAR, LD_MDR, MEM_REQ, MEM_WE;
    logic [15:0] Data_from_SRAM;
    logic [15:0] MAR, MDR, ADDR, Data_to_SRAM;
    logic        mem_rd, mem_wr, BUSY, MEM_RDY;

    mem_access_unit #(.MEM_LATENCY(LAT)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .BUS            (BUS),
        .LD_MAR         (LD_MAR),
        .LD_MDR         (LD_MDR),
        .MEM_REQ        (MEM_REQ),
        .MEM_WE         (MEM_WE),
        .Data_from_SRAM (Data_from_SRAM),
        .MAR            (MAR),
        .MDR            (MDR),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .BUSY           (BUSY),
        .MEM_RDY        (MEM_RDY)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdr;
        int          rdy_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] mdr,
                            input int rdy_cyc);
        exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.mdr = mdr; e.rdy_cyc = rdy_cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d accesses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: checks strobes against the head expectation, pops on MEM_RDY.
    always @(negedge Clk) begin
        if (Reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            chk("busy_vs_strobe", {31'b0, BUSY}, {31'b0, mem_rd | mem_wr});
            chk("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
            if (mem_rd || mem_wr) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_strobe: rd=%0b wr=%0b, expected none", mem_rd, mem_wr);
                end else begin
                    chk("strobe_addr", {16'b0, ADDR}, {16'b0, q[0].addr});
                    chk("strobe_type", {31'b0, mem_wr}, {31'b0, q[0].we});
                    if (mem_wr) chk("wr_data", {16'b0, Data_to_SRAM}, {16'b0, q[0].wdata});
                    if (mem_rd) rd_cnt++;
                    if (mem_wr) wr_cnt++;
                end
            end
            if (MEM_RDY) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rdy: MEM_RDY=1, expected 0");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdy_cycle", cyc, e.rdy_cyc);
                    chk("rdy_mdr", {16'b0, MDR}, {16'b0, e.mdr});
                    chk("rd_strobe_len", rd_cnt, e.we ? 0 : LAT);
                    chk("wr_strobe_len", wr_cnt, e.we ? LAT : 0);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    initial begin
        Reset = 1'b1; BUS = '0; LD_MAR = 1'b0; LD_MDR = 1'b0;
        MEM_REQ = 1'b0; MEM_WE = 1'b0; Data_from_SRAM = '0;
        step();

        // Reset held two cycles while LD_MAR asserted
        LD_MAR = 1'b1; BUS = 16'h1234;
        step(); step();
        chk("rst_MAR", {16'b0, MAR}, 32'h0);
        chk("rst_MDR", {16'b0, MDR}, 32'h0);
        chk("rst_flags", {28'b0, mem_rd, mem_wr, BUSY, MEM_RDY}, 32'h0);
        Reset = 1'b0; LD_MAR = 1'b0;

        // Read from x0040
        LD_MAR = 1'b1; BUS = 16'h0040;
        step();
        LD_MAR = 1'b0;
        MEM_REQ = 1'b1; MEM_WE = 1'b0; Data_from_SRAM = 16'hBEEF;
        push_exp(1'b0, 16'h0040, 16'h0, 16'hBEEF, cyc + LAT + 1);
        step();
        MEM_REQ = 1'b0;
        drain();
        chk("rd_MAR_after", {16'b0, MAR}, 32'h0040);

        // Write xCAFE to x0041
        LD_MAR = 1'b1; BUS = 16'h0041;
        step();
        LD_MAR = 1'b0; LD_MDR = 1'b1; BUS = 16'hCAFE;
        step();
        LD_MDR = 1'b0; BUS = 16'h0;
        MEM_REQ = 1'b1; MEM_WE = 1'b1; Data_from_SRAM = 16'h1111;
        push_exp(1'b1, 16'h0041, 16'hCAFE, 16'hCAFE, cyc + LAT + 1);
        step();
        MEM_REQ = 1'b0; MEM_WE = 1'b0;
        drain();
        chk("wr_MDR_after", {16'b0, MDR}, 32'hCAFE);

        // Loads attempted during WAIT are ignored
        LD_MAR = 1'b1; BUS = 16'h0040;
        step();
        LD_MAR = 1'b0;
        MEM_REQ = 1'b1; MEM_WE = 1'b0; Data_from_SRAM = 16'h5A5A;
        push_exp(1'b0, 16'h0040, 16'h0, 16'h5A5A, cyc + LAT + 1);
        step();
        MEM_REQ = 1'b0; LD_MAR = 1'b1; BUS = 16'h9999;
        step();
        LD_MAR = 1'b0; LD_MDR = 1'b1; BUS = 16'h7777;
        step();
        LD_MDR = 1'b0; BUS = 16'h0;
        drain();
        chk("wait_ld_MAR", {16'b0, MAR}, 32'h0040);
        chk("wait_ld_MDR", {16'b0, MDR}, 32'h5A5A);

        // Back-to-back: MEM_REQ held 7 cycles, accepts at 0, 3, 6;
        // read data sampled in cycles 2, 5, 8
        push_exp(1'b0, 16'h0040, 16'h0, 16'h1002, cyc + 3);
        push_exp(1'b0, 16'h0040, 16'h0, 16'h1005, cyc + 6);
        push_exp(1'b0, 16'h0040, 16'h0, 16'h1008, cyc + 9);
        for (int i = 0; i < 10; i++) begin
            MEM_REQ = (i < 7);
            MEM_WE = 1'b0;
            Data_from_SRAM = 16'h1000 + 16'(i);
            step();
        end
        MEM_REQ = 1'b0;
        drain();

        // Reset in the first WAIT cycle aborts the access
        MEM_REQ = 1'b1; MEM_WE = 1'b0; Data_from_SRAM = 16'hABCD;
        push_exp(1'b0, 16'h0040, 16'h0, 16'hABCD, cyc + LAT + 1);
        step();
        MEM_REQ = 1'b0; Reset = 1'b1;
        step();
        Reset = 1'b0;
        q.delete();
        chk("abort_rd", {31'b0, mem_rd}, 32'h0);
        chk("abort_busy", {31'b0, BUSY}, 32'h0);
        chk("abort_rdy", {31'b0, MEM_RDY}, 32'h0);
        chk("abort_MDR", {16'b0, MDR}, 32'h0);
        repeat (5) step();
        chk("abort_MDR_late", {16'b0, MDR}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
